// File: rtl/multi_segment_waveform_capture_if.sv
// multi_segment_waveform_capture_if: capture config, sample stream, status and readback bus
interface multi_segment_waveform_capture_if #(
  parameter int NCHAN = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int SEG_WIDTH = 4,
  parameter int TRIGGER_WIDTH = 8,
  parameter int DECIM_WIDTH = 8,
  parameter int TS_WIDTH = 64,
  parameter int AW = $clog2(DEPTH)
);
  logic arm, abort, soft_trigger, valid;
  logic [AW:0] pretrig_count, acq_count;
  logic [SEG_WIDTH-1:0] seg_count, seg_sel, seg_done_count;
  logic [DECIM_WIDTH-1:0] decimation;
  logic [TRIGGER_WIDTH-1:0] trigger_mask, triggers;
  logic [NCHAN*DATA_WIDTH-1:0] data, rd_data;
  logic [TS_WIDTH-1:0] timestamp, seg_timestamp;
  logic [AW-1:0] rd_addr, seg_start_addr;
  logic busy, pretrig_done, done, config_error;
  modport master (
    output arm, abort, soft_trigger, valid, pretrig_count, acq_count, seg_count, seg_sel,
           decimation, trigger_mask, triggers, data, timestamp, rd_addr,
    input  busy, pretrig_done, done, config_error, seg_done_count, rd_data, seg_start_addr, seg_timestamp
  );
  modport slave (
    input  arm, abort, soft_trigger, valid, pretrig_count, acq_count, seg_count, seg_sel,
           decimation, trigger_mask, triggers, data, timestamp, rd_addr,
    output busy, pretrig_done, done, config_error, seg_done_count, rd_data, seg_start_addr, seg_timestamp
  );
endinterface

// File: rtl/multi_segment_waveform_capture.sv
// multi_segment_waveform_capture: segmented pretrigger waveform recorder with decimation and edge triggers
module multi_segment_waveform_capture #(
  parameter int NCHAN = 4,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int SEG_WIDTH = 4,
  parameter int TRIGGER_WIDTH = 8,
  parameter int DECIM_WIDTH = 8,
  parameter int TS_WIDTH = 64
) (
  input logic clk,
  input logic rst_n,
  multi_segment_waveform_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W = NCHAN * DATA_WIDTH;
  typedef enum logic [2:0] {IDLE, FILL, ARMED, POST, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] ram [DEPTH];
  logic [W-1:0] rd_q;
  logic [AW-1:0] start_mem [2**SEG_WIDTH];
  logic [TS_WIDTH-1:0] ts_mem [2**SEG_WIDTH];
  logic [AW:0] pre, acq, fill_cnt, post_cnt, seg_base, next_base, post_len, wr_off, ptr_inc;
  logic [AW-1:0] wr_ptr, start_addr, start_nx, seg_start;
  logic [SEG_WIDTH-1:0] segs;
  logic [DECIM_WIDTH-1:0] decim, decim_cnt;
  logic [TRIGGER_WIDTH-1:0] mask, trig_prev;
  logic [TS_WIDTH-1:0] trig_ts;
  logic [SEG_WIDTH+AW:0] total;
  logic acc, trig, wr_en, seg_end, start_write, cfg_bad, arm_ok;
  assign acc = bus.valid && decim_cnt == '0;
  assign trig = |(bus.triggers & ~trig_prev & mask) | bus.soft_trigger;
  assign post_len = acq - pre;
  assign next_base = seg_base + acq;
  assign ptr_inc = {1'b0, wr_ptr} + 1'b1;
  assign wr_off = {1'b0, wr_ptr} - seg_base;
  // start = trigger address minus pretrigger depth, wrapped inside the current segment
  assign start_nx = wr_ptr + (wr_off >= pre ? '0 : acq[AW-1:0]) - pre[AW-1:0];
  assign seg_start = start_write ? start_nx : start_addr;
  assign total = {{(AW+1){1'b0}}, bus.seg_count} * {{SEG_WIDTH{1'b0}}, bus.acq_count};
  assign cfg_bad = bus.acq_count == '0 || bus.pretrig_count >= bus.acq_count || bus.seg_count == '0 ||
                   total > (SEG_WIDTH+AW+1)'(DEPTH);
  assign arm_ok = (state == IDLE || state == DONE) && bus.arm && !bus.abort;
  assign bus.busy = state == FILL || state == ARMED || state == POST;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    wr_en = 1'b0;
    seg_end = 1'b0;
    start_write = 1'b0;
    if (state == FILL) begin
      wr_en = acc && fill_cnt != pre;
      if (fill_cnt + (AW+1)'(wr_en) == pre) state_nx = ARMED;
    end else if (state == ARMED) begin
      wr_en = acc;
      start_write = acc && trig;
      if (trig) state_nx = POST;
    end else if (state == POST) begin
      wr_en = acc && post_cnt != post_len;
      start_write = wr_en && post_cnt == '0;
      seg_end = post_cnt + (AW+1)'(wr_en) == post_len;
      if (seg_end) state_nx = bus.seg_done_count + SEG_WIDTH'(1) == segs ? DONE : FILL;
    end else if (bus.arm) state_nx = cfg_bad ? IDLE : FILL;
    if (bus.abort) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      acq <= '0;
      segs <= '0;
      decim <= '0;
      mask <= '0;
      decim_cnt <= '0;
      trig_prev <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
      seg_base <= '0;
      wr_ptr <= '0;
      start_addr <= '0;
      trig_ts <= '0;
      bus.pretrig_done <= 1'b0;
      bus.done <= 1'b0;
      bus.config_error <= 1'b0;
      bus.seg_done_count <= '0;
      bus.seg_start_addr <= '0;
      bus.seg_timestamp <= '0;
      bus.rd_data <= '0;
    end else begin
      trig_prev <= bus.triggers;
      bus.rd_data <= rd_q;
      bus.seg_start_addr <= start_mem[bus.seg_sel];
      bus.seg_timestamp <= ts_mem[bus.seg_sel];
      if (arm_ok) begin
        pre <= bus.pretrig_count;
        acq <= bus.acq_count;
        segs <= bus.seg_count;
        decim <= bus.decimation;
        mask <= bus.trigger_mask;
        decim_cnt <= '0;
        fill_cnt <= '0;
        seg_base <= '0;
        wr_ptr <= '0;
        bus.done <= 1'b0;
        bus.seg_done_count <= '0;
        bus.config_error <= cfg_bad;
      end
      if (bus.busy && bus.valid) decim_cnt <= decim_cnt == '0 ? decim : decim_cnt - 1'b1;
      if (wr_en) wr_ptr <= ptr_inc == next_base ? seg_base[AW-1:0] : ptr_inc[AW-1:0];
      if (state == FILL) fill_cnt <= fill_cnt + (AW+1)'(wr_en);
      if (state == FILL && state_nx == ARMED) bus.pretrig_done <= 1'b1;
      if (state == ARMED && trig) begin
        trig_ts <= bus.timestamp;
        post_cnt <= (AW+1)'(acc);
      end
      if (state == POST) post_cnt <= post_cnt + (AW+1)'(wr_en);
      if (start_write) start_addr <= start_nx;
      if (seg_end) begin
        bus.seg_done_count <= bus.seg_done_count + 1'b1;
        bus.pretrig_done <= 1'b0;
        if (state_nx == DONE) bus.done <= 1'b1;
        else begin
          seg_base <= next_base;
          wr_ptr <= next_base[AW-1:0];
          fill_cnt <= '0;
        end
      end
      if (bus.abort) bus.pretrig_done <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr] <= bus.data;
    if (seg_end) begin
      start_mem[bus.seg_done_count] <= seg_start;
      ts_mem[bus.seg_done_count] <= trig_ts;
    end
    rd_q <= ram[bus.rd_addr];
  end
endmodule

// File: tb/tb_multi_segment_waveform_capture.sv
// tb_multi_segment_waveform_capture: directed scenarios with hand-computed expectations
module tb_multi_segment_waveform_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0, checks = 0, cyc = 0, dcount = 0, vcnt = 0, vper = 1;
  always #5 clk = ~clk;
  multi_segment_waveform_capture_if bus ();
  multi_segment_waveform_capture dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [63:0] word(input int v);
    logic [15:0] x;
    x = v[15:0];
    return {4{x}};
  endfunction

  // advance one clock; the sample source emits counter words every vper cycles
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.timestamp = 64'(cyc);
    if (vcnt == 0) begin
      bus.valid = 1'b1;
      bus.data = word(dcount);
      dcount++;
    end else bus.valid = 1'b0;
    vcnt = (vcnt >= vper - 1) ? 0 : vcnt + 1;
  endtask

  task automatic configure(input int pre, input int acq, input int segs, input int decim, input int mask, input int per);
    bus.pretrig_count = 11'(pre);
    bus.acq_count = 11'(acq);
    bus.seg_count = 4'(segs);
    bus.decimation = 8'(decim);
    bus.trigger_mask = 8'(mask);
    vper = per;
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    bus.valid = 1'b0;
    dcount = 0;
    vcnt = 0;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic fire_soft(output int tv, output longint ts);
    bus.soft_trigger = 1'b1;
    tv = bus.valid ? dcount - 1 : dcount;
    ts = longint'(cyc);
    tick();
    bus.soft_trigger = 1'b0;
  endtask

  task automatic wait_pretrig(input int lim);
    for (int n = 0; n < lim && bus.pretrig_done !== 1'b1; n++) tick();
  endtask

  task automatic wait_done(input int lim);
    for (int n = 0; n < lim && bus.done !== 1'b1; n++) tick();
  endtask

  task automatic wait_segs(input int k, input int lim);
    for (int n = 0; n < lim && int'(bus.seg_done_count) < k; n++) tick();
  endtask

  task automatic read_ram(input int a, output logic [63:0] w);
    bus.rd_addr = 10'(a);
    tick();
    tick();
    w = bus.rd_data;
  endtask

  task automatic read_seg(input int s, output int start, output logic [63:0] ts);
    bus.seg_sel = 4'(s);
    tick();
    start = int'(bus.seg_start_addr);
    ts = bus.seg_timestamp;
  endtask

  task automatic test_reset();
    logic [170:0] o;
    tick();
    tick();
    o = {bus.busy, bus.pretrig_done, bus.done, bus.config_error, bus.seg_done_count,
         bus.seg_start_addr, bus.seg_timestamp, bus.rd_data};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_outputs got=%0h want=0", o); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int tv, start, bad;
    longint tsx;
    logic [63:0] w, ts;
    configure(32, 128, 1, 0, 0, 16);
    do_arm();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b want=1", bus.busy); end
    wait_pretrig(1000);
    checks++;
    if (bus.pretrig_done !== 1'b1) begin errors++; $display("FAIL single_pretrig got=%b want=1", bus.pretrig_done); end
    repeat (100) tick();
    fire_soft(tv, tsx);
    wait_done(3000);
    checks++;
    if ({bus.done, bus.busy, bus.seg_done_count} !== {1'b1, 1'b0, 4'd1}) begin
      errors++; $display("FAIL single_done got=%b%b/%0d want=10/1", bus.done, bus.busy, bus.seg_done_count);
    end
    read_seg(0, start, ts);
    checks++;
    if (start !== ((tv - 32) & 127)) begin errors++; $display("FAIL single_start got=%0d want=%0d", start, (tv - 32) & 127); end
    checks++;
    if (ts !== 64'(tsx)) begin errors++; $display("FAIL single_ts got=%0d want=%0d", ts, tsx); end
    read_ram((start + 32) & 127, w);
    checks++;
    if (w !== word(tv)) begin errors++; $display("FAIL single_trig_word got=%h want=%h", w, word(tv)); end
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      read_ram((start + k) & 127, w);
      if (w !== word(tv - 32 + k)) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL single_sequence got=%0d bad words want=0", bad); end
  endtask

  task automatic test_multi();
    int tv[4];
    int start, base;
    logic [63:0] w, ts;
    configure(16, 64, 4, 0, 8'h20, 1);
    do_arm();
    wait_pretrig(200);
    bus.triggers = 8'h01;
    tick();
    bus.triggers = 8'h00;
    tick();
    checks++;
    if ({bus.pretrig_done, bus.seg_done_count} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL multi_masked got=%b/%0d want=1/0", bus.pretrig_done, bus.seg_done_count);
    end
    for (int s = 0; s < 4; s++) begin
      wait_pretrig(200);
      bus.triggers = 8'h20;
      tv[s] = dcount - 1;
      tick();
      bus.triggers = 8'h00;
      wait_segs(s + 1, 200);
    end
    checks++;
    if ({bus.done, bus.seg_done_count} !== {1'b1, 4'd4}) begin
      errors++; $display("FAIL multi_done got=%b/%0d want=1/4", bus.done, bus.seg_done_count);
    end
    for (int s = 0; s < 4; s++) begin
      base = 64 * s;
      read_seg(s, start, ts);
      checks++;
      if (start < base || start >= base + 64) begin errors++; $display("FAIL multi_start%0d got=%0d want=[%0d,%0d)", s, start, base, base + 64); end
      read_ram(base + ((start - base + 16) & 63), w);
      checks++;
      if (w !== word(tv[s])) begin errors++; $display("FAIL multi_trig%0d got=%h want=%h", s, w, word(tv[s])); end
      read_ram(start, w);
      checks++;
      if (w !== word(tv[s] - 16)) begin errors++; $display("FAIL multi_pre%0d got=%h want=%h", s, w, word(tv[s] - 16)); end
    end
  endtask

  task automatic test_config();
    configure(0, 512, 3, 0, 0, 1);
    do_arm();
    checks++;
    if ({bus.config_error, bus.busy} !== 2'b10) begin errors++; $display("FAIL cfg_product got=%b%b want=10", bus.config_error, bus.busy); end
    configure(64, 64, 1, 0, 0, 1);
    do_arm();
    checks++;
    if ({bus.config_error, bus.busy} !== 2'b10) begin errors++; $display("FAIL cfg_pre_eq_acq got=%b%b want=10", bus.config_error, bus.busy); end
    configure(0, 0, 1, 0, 0, 1);
    do_arm();
    checks++;
    if ({bus.config_error, bus.busy} !== 2'b10) begin errors++; $display("FAIL cfg_acq_zero got=%b%b want=10", bus.config_error, bus.busy); end
    configure(0, 512, 2, 0, 0, 1);
    do_arm();
    checks++;
    if ({bus.config_error, bus.busy} !== 2'b01) begin errors++; $display("FAIL cfg_full_depth got=%b%b want=01", bus.config_error, bus.busy); end
    tick();
    checks++;
    if (bus.pretrig_done !== 1'b1) begin errors++; $display("FAIL cfg_pre_zero got=%b want=1", bus.pretrig_done); end
    configure(0, 0, 1, 0, 0, 1);
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    checks++;
    if ({bus.config_error, bus.busy} !== 2'b01) begin errors++; $display("FAIL cfg_arm_busy got=%b%b want=01", bus.config_error, bus.busy); end
    do_abort();
  endtask

  task automatic test_fill_trigger();
    configure(4, 16, 2, 0, 8'h01, 1);
    do_arm();
    bus.triggers = 8'h01;
    tick();
    bus.triggers = 8'h00;
    wait_pretrig(50);
    repeat (3) tick();
    checks++;
    if ({bus.pretrig_done, bus.seg_done_count} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL fill_trig_ignored got=%b/%0d want=1/0", bus.pretrig_done, bus.seg_done_count);
    end
    bus.triggers = 8'h01;
    repeat (50) tick();
    checks++;
    if ({bus.seg_done_count, bus.busy, bus.done} !== {4'd1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL level_once got=%0d/%b%b want=1/10", bus.seg_done_count, bus.busy, bus.done);
    end
    bus.triggers = 8'h00;
    do_abort();
  endtask

  task automatic test_decimation();
    int tv, acc_v, start, bad;
    longint tsx;
    logic [63:0] w, ts;
    logic [63:0] mem[32];
    configure(8, 32, 1, 3, 0, 1);
    do_arm();
    wait_pretrig(200);
    fire_soft(tv, tsx);
    acc_v = ((tv + 3) / 4) * 4;
    wait_done(300);
    checks++;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL decim_done got=%b want=1", bus.done); end
    read_seg(0, start, ts);
    checks++;
    if (start !== ((acc_v / 4 - 8) & 31)) begin errors++; $display("FAIL decim_start got=%0d want=%0d", start, (acc_v / 4 - 8) & 31); end
    for (int k = 0; k < 32; k++) read_ram((start + k) & 31, mem[k]);
    checks++;
    if (mem[8] !== word(acc_v)) begin errors++; $display("FAIL decim_trig got=%h want=%h", mem[8], word(acc_v)); end
    bad = 0;
    for (int k = 0; k < 31; k++) if (mem[k + 1] !== word(int'(mem[k][15:0]) + 4)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL decim_step got=%0d bad steps want=0", bad); end
    w = mem[0];
  endtask

  task automatic test_abort();
    int tv, start;
    longint tsx;
    logic [63:0] w, ts;
    logic [170:0] o;
    configure(8, 32, 1, 0, 0, 1);
    do_arm();
    wait_pretrig(100);
    fire_soft(tv, tsx);
    repeat (3) tick();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_in_post got=%b want=1", bus.busy); end
    do_abort();
    checks++;
    if ({bus.busy, bus.pretrig_done} !== 2'b00) begin errors++; $display("FAIL abort_idle got=%b%b want=00", bus.busy, bus.pretrig_done); end
    do_arm();
    wait_pretrig(100);
    fire_soft(tv, tsx);
    wait_done(100);
    checks++;
    if ({bus.done, bus.seg_done_count} !== {1'b1, 4'd1}) begin
      errors++; $display("FAIL rearm_done got=%b/%0d want=1/1", bus.done, bus.seg_done_count);
    end
    read_seg(0, start, ts);
    checks++;
    if (start !== ((tv - 8) & 31)) begin errors++; $display("FAIL rearm_start got=%0d want=%0d", start, (tv - 8) & 31); end
    read_ram((start + 8) & 31, w);
    checks++;
    if (w !== word(tv)) begin errors++; $display("FAIL rearm_trig got=%h want=%h", w, word(tv)); end
    do_arm();
    wait_pretrig(100);
    fire_soft(tv, tsx);
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    o = {bus.busy, bus.pretrig_done, bus.done, bus.config_error, bus.seg_done_count,
         bus.seg_start_addr, bus.seg_timestamp, bus.rd_data};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_mid_post got=%0h want=0", o); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    bus.soft_trigger = 1'b0;
    bus.valid = 1'b0;
    bus.data = '0;
    bus.triggers = '0;
    bus.timestamp = '0;
    bus.rd_addr = '0;
    bus.seg_sel = '0;
    configure(0, 0, 0, 0, 0, 1);
    test_reset();
    test_single();
    test_multi();
    test_config();
    test_fill_trigger();
    test_decimation();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
